consmax_cfg_loader: RTL and testbench
=====================================

Name: consmax_cfg_loader

Overview:
Configuration sequencer that drives the LUT-write and dequant-scale inputs of the consmax vector engine from a streamed configuration source (DMA or config SRAM).
- Accepts a fixed-format word stream over a valid/ready handshake.
- Issues the scale update and all 2×LUT_DEPTH LUT writes in address order.
- Asserts a hold to upstream data producers while writes pre-empt LUT reads.
- One instance fans out to all BUS_NUM consmax blocks, which share the LUT/scale interface.

Parameters:
- FIXED_BIT, 8, fixed-point data width of the consmax datapath.
- EXP_BIT, 8, FP exponent width.
- MAT_BIT, 7, FP mantissa width.
- LUT_DATA, EXP_BIT+MAT_BIT+1, FP word width of LUT entries and scale.
- LUT_ADDR, FIXED_BIT>>1, per-LUT address width.
- LUT_DEPTH, 2**LUT_ADDR, entries per LUT; total entries = 2*LUT_DEPTH.
- HOLD_TAIL, 2, cycles data_hold stays high after the last LUT write.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- abort  input  1  one-cycle pulse; terminates a load in progress.
- cfg_data  input  LUT_DATA  configuration word.
- cfg_vld  input  1  cfg_data valid.
- cfg_rdy  output  1  loader accepts cfg_data this cycle.
- out_scale  output  LUT_DATA  dequant scale to consmax.
- out_scale_vld  output  1  one-cycle strobe qualifying out_scale.
- lut_waddr  output  LUT_ADDR+1  LUT write address; MSB selects LUT (0 = low nibble, 1 = high nibble).
- lut_wen  output  1  LUT write enable.
- lut_wdata  output  LUT_DATA  LUT write data.
- data_hold  output  1  upstream must deassert in_fixed_data_vld while high.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when a load completes normally.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values of all outputs are 0: cfg_rdy, out_scale, out_scale_vld, lut_waddr, lut_wen, lut_wdata, data_hold, busy, done.
- Stream format per load: word 0 = scale. Words 1..2*LUT_DEPTH = LUT entries; word w is written to lut_waddr = w-1, so LUT0[0..15] come first, then LUT1[0..15]. Total 33 words at default parameters.
- FSM states:
  - IDLE: cfg_rdy=0, busy=0. start=1 and abort=0 → SCALE; data_hold rises the same edge.
  - SCALE: cfg_rdy=1. On handshake (cfg_vld & cfg_rdy), the next cycle has out_scale=cfg_data and out_scale_vld=1 for exactly 1 cycle → LUT, with the 5-bit address counter at 0.
  - LUT: cfg_rdy=1. On handshake, the next cycle has lut_wen=1, lut_waddr=counter, lut_wdata=cfg_data, and the counter increments. The handshake at counter = 2*LUT_DEPTH-1 → TAIL. Gaps in cfg_vld produce gaps in lut_wen; lut_waddr and lut_wdata hold their last value while lut_wen=0.
  - TAIL: cfg_rdy=0. Count HOLD_TAIL cycles after the last lut_wen cycle, then data_hold falls and done pulses for 1 cycle in the same cycle → IDLE.
- Registered outputs: every output except cfg_rdy is registered. Latency from handshake to the write strobe is exactly 1 cycle. cfg_rdy is decoded from state only and never depends on cfg_vld.
- busy = 1 in SCALE, LUT and TAIL.
- out_scale keeps its last loaded value after out_scale_vld drops and after abort. It resets only on rst_n.
- start while busy is ignored; no restart and no error.
- abort in SCALE, LUT or TAIL: next cycle → IDLE with lut_wen=0, out_scale_vld=0, data_hold=0, and no done pulse. A handshake in the same cycle as abort is discarded and produces no write.
- start and abort in the same cycle while idle: abort wins and the FSM stays in IDLE.
- Asynchronous reset mid-load returns immediately to IDLE with all outputs 0. The partial LUT contents are left to the consmax RAMs, which are not reset.
- The address counter never wraps within a load. Leaving LUT requires exactly 2*LUT_DEPTH writes.
- cfg_vld while cfg_rdy=0 is not consumed; the source must hold the word.

Test Plan:
- Full load with cfg_vld always high, scale=16'h3F80 and entry w = 16'h4000+w: out_scale_vld pulses once with 16'h3F80 one cycle after the first handshake. Then 32 consecutive lut_wen cycles with lut_waddr 0..31 and wdata 16'h4001..16'h4020. data_hold falls and done pulses 2 cycles after the last write.
- Same load with cfg_vld toggling every other cycle: writes occur only one cycle after each handshake, addresses stay gap-free 0..31, and busy stays high throughout.
- abort asserted after 10 LUT handshakes: exactly 10 writes (addr 0..9), a handshake coincident with abort produces no write, the FSM returns to IDLE next cycle, there is no done pulse, and out_scale retains the loaded value.
- rst_n pulled low mid-LUT (addr 20): all outputs are 0 asynchronously. After reset release, a new start runs a full load from addr 0.
- start pulsed during LUT: ignored, the sequence is unchanged, and exactly one done pulse occurs. start+abort together in IDLE: busy stays 0.
- cfg_vld high in IDLE and TAIL with no start: cfg_rdy stays 0 and no lut_wen or out_scale_vld is produced.

Source files
------------

// File: rtl/consmax_cfg_loader_if.sv
// Configuration stream plus LUT/scale write bus between the loader and the consmax engines.
// master: the loader (accepts the stream, drives the write bus); slave: source/consumer side.
interface consmax_cfg_loader_if #(
  parameter int LUT_DATA = 16,
  parameter int LUT_ADDR = 4
);
  logic [LUT_DATA-1:0] cfg_data;
  logic                cfg_vld;
  logic                cfg_rdy;
  logic [LUT_DATA-1:0] out_scale;
  logic                out_scale_vld;
  logic [LUT_ADDR:0]   lut_waddr;
  logic                lut_wen;
  logic [LUT_DATA-1:0] lut_wdata;

  modport master (
    input  cfg_data, cfg_vld,
    output cfg_rdy, out_scale, out_scale_vld, lut_waddr, lut_wen, lut_wdata
  );

  modport slave (
    output cfg_data, cfg_vld,
    input  cfg_rdy, out_scale, out_scale_vld, lut_waddr, lut_wen, lut_wdata
  );
endinterface

// File: rtl/consmax_cfg_loader.sv
// Streams one scale word then 2*LUT_DEPTH LUT entries into the shared consmax LUT/scale
// write port, holding upstream data producers off while the writes are in flight.
module consmax_cfg_loader #(
  parameter int FIXED_BIT = 8,
  parameter int EXP_BIT   = 8,
  parameter int MAT_BIT   = 7,
  parameter int LUT_DATA  = EXP_BIT + MAT_BIT + 1,
  parameter int LUT_ADDR  = FIXED_BIT >> 1,
  parameter int LUT_DEPTH = 2 ** LUT_ADDR,
  parameter int HOLD_TAIL = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  consmax_cfg_loader_if.master          bus,
  output logic                          data_hold,
  output logic                          busy,
  output logic                          done
);

  localparam int TAIL_W = (HOLD_TAIL > 1) ? $clog2(HOLD_TAIL) : 1;
  localparam logic [LUT_ADDR:0] LAST_ADDR = {(LUT_ADDR+1){1'b1}};

  typedef enum logic [1:0] {IDLE, SCALE, LUT, TAIL} state_t;

  state_t              state_reg;
  logic [LUT_ADDR:0]   cnt_reg;
  logic [TAIL_W-1:0]   tail_reg;
  logic [LUT_DATA-1:0] scale_reg;
  logic                scale_vld_reg;
  logic [LUT_ADDR:0]   waddr_reg;
  logic                wen_reg;
  logic [LUT_DATA-1:0] wdata_reg;
  logic                hold_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                hs;

  // Ready is a pure state decode so the source never sees a combinational path from its own valid.
  assign bus.cfg_rdy = (state_reg == SCALE) || (state_reg == LUT);
  assign hs          = bus.cfg_vld && bus.cfg_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      tail_reg      <= '0;
      scale_reg     <= '0;
      scale_vld_reg <= 1'b0;
      waddr_reg     <= '0;
      wen_reg       <= 1'b0;
      wdata_reg     <= '0;
      hold_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      scale_vld_reg <= 1'b0;
      wen_reg       <= 1'b0;
      done_reg      <= 1'b0;
      // Abort outranks any handshake in the same cycle; that word is dropped.
      if (state_reg != IDLE && abort) begin
        state_reg <= IDLE;
        hold_reg  <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !abort) begin
              state_reg <= SCALE;
              hold_reg  <= 1'b1;
              busy_reg  <= 1'b1;
            end
          end
          SCALE: begin
            if (hs) begin
              scale_reg     <= bus.cfg_data;
              scale_vld_reg <= 1'b1;
              cnt_reg       <= '0;
              state_reg     <= LUT;
            end
          end
          LUT: begin
            if (hs) begin
              wen_reg   <= 1'b1;
              waddr_reg <= cnt_reg;
              wdata_reg <= bus.cfg_data;
              cnt_reg   <= cnt_reg + 1'b1;
              if (cnt_reg == LAST_ADDR) begin
                tail_reg  <= '0;
                state_reg <= TAIL;
              end
            end
          end
          TAIL: begin
            if (tail_reg == TAIL_W'(HOLD_TAIL - 1)) begin
              hold_reg  <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              tail_reg <= tail_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_scale     = scale_reg;
  assign bus.out_scale_vld = scale_vld_reg;
  assign bus.lut_waddr     = waddr_reg;
  assign bus.lut_wen       = wen_reg;
  assign bus.lut_wdata     = wdata_reg;
  assign data_hold         = hold_reg;
  assign busy              = busy_reg;
  assign done              = done_reg;

endmodule

// File: tb/tb_consmax_cfg_loader.sv
// Directed, table-driven bench for consmax_cfg_loader: one record per clock cycle with the
// inputs driven in that cycle and the registered outputs expected just after its rising edge.
module tb_consmax_cfg_loader;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic data_hold;
  logic busy;
  logic done;

  consmax_cfg_loader_if #(.LUT_DATA(16), .LUT_ADDR(4)) bus ();

  consmax_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .bus       (bus.master),
    .data_hold (data_hold),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    bit          ab;
    bit          vld;
    logic [15:0] data;
    bit          rdy;
    bit          wen;
    logic [4:0]  waddr;
    logic [15:0] wdata;
    bit          svld;
    logic [15:0] scale;
    bit          hold;
    bit          bsy;
    bit          dn;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int          step   = 0;
  logic [15:0] m_scale = '0;
  logic [4:0]  m_addr  = '0;
  logic [15:0] m_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic push(input bit st, input bit ab, input bit vld, input logic [15:0] d,
                      input bit rdy, input bit wen, input bit svld,
                      input bit hold, input bit bsy, input bit dn);
    vec_t v;
    v.st = st; v.ab = ab; v.vld = vld; v.data = d;
    v.rdy = rdy; v.wen = wen; v.waddr = m_addr; v.wdata = m_wdata;
    v.svld = svld; v.scale = m_scale; v.hold = hold; v.bsy = bsy; v.dn = dn;
    vecs.push_back(v);
  endtask

  // Full load: optional single-cycle vld gaps before every word, optional stray start pulses.
  task automatic build_load(input logic [15:0] sc, input logic [15:0] base,
                            input bit gaps, input int start_k);
    push(1, 0, 0, 16'h0, 0, 0, 0, 1, 1, 0);
    if (gaps) push(0, 0, 0, 16'h0, 1, 0, 0, 1, 1, 0);
    m_scale = sc;
    push(0, 0, 1, sc, 1, 0, 1, 1, 1, 0);
    for (int k = 0; k < 32; k++) begin
      if (gaps) push(0, 0, 0, 16'hFFFF, 1, 0, 0, 1, 1, 0);
      m_addr  = 5'(k);
      m_wdata = base + 16'(k + 1);
      push(k == start_k, 0, 1, m_wdata, 1, 1, 0, 1, 1, 0);
    end
    push(start_k >= 0, 0, 1, 16'hDEAD, 0, 0, 0, 1, 1, 0);
    push(0, 0, 1, 16'hDEAD, 0, 0, 0, 0, 0, 1);
    push(0, 0, 1, 16'hBEEF, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic build_partial(input logic [15:0] sc, input logic [15:0] base, input int n);
    push(1, 0, 0, 16'h0, 0, 0, 0, 1, 1, 0);
    m_scale = sc;
    push(0, 0, 1, sc, 1, 0, 1, 1, 1, 0);
    for (int k = 0; k < n; k++) begin
      m_addr  = 5'(k);
      m_wdata = base + 16'(k);
      push(0, 0, 1, m_wdata, 1, 1, 0, 1, 1, 0);
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      @(negedge clk);
      start        = vecs[i].st;
      abort        = vecs[i].ab;
      bus.cfg_vld  = vecs[i].vld;
      bus.cfg_data = vecs[i].data;
      #1;
      chk("cfg_rdy", 32'(bus.cfg_rdy), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk("lut_wen",       32'(bus.lut_wen),       32'(vecs[i].wen));
      chk("lut_waddr",     32'(bus.lut_waddr),     32'(vecs[i].waddr));
      chk("lut_wdata",     32'(bus.lut_wdata),     32'(vecs[i].wdata));
      chk("out_scale_vld", 32'(bus.out_scale_vld), 32'(vecs[i].svld));
      chk("out_scale",     32'(bus.out_scale),     32'(vecs[i].scale));
      chk("data_hold",     32'(data_hold),         32'(vecs[i].hold));
      chk("busy",          32'(busy),              32'(vecs[i].bsy));
      chk("done",          32'(done),              32'(vecs[i].dn));
      step++;
    end
    vecs.delete();
    start       = 1'b0;
    abort       = 1'b0;
    bus.cfg_vld = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg_rdy"},   32'(bus.cfg_rdy),       32'd0);
    chk({tag, "_scale"},     32'(bus.out_scale),     32'd0);
    chk({tag, "_scale_vld"}, 32'(bus.out_scale_vld), 32'd0);
    chk({tag, "_waddr"},     32'(bus.lut_waddr),     32'd0);
    chk({tag, "_wen"},       32'(bus.lut_wen),       32'd0);
    chk({tag, "_wdata"},     32'(bus.lut_wdata),     32'd0);
    chk({tag, "_hold"},      32'(data_hold),         32'd0);
    chk({tag, "_busy"},      32'(busy),              32'd0);
    chk({tag, "_done"},      32'(done),              32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    bus.cfg_vld  = 1'b0;
    bus.cfg_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back full load, then the same load with a gap before every word.
    build_load(16'h3F80, 16'h4000, 1'b0, -1);
    run_table();
    build_load(16'h3F80, 16'h4000, 1'b1, -1);
    run_table();

    // Abort after 10 LUT writes; the coincident handshake must not write.
    build_partial(16'h1234, 16'h5000, 10);
    push(0, 1, 1, 16'h0BAD, 1, 0, 0, 0, 0, 0);
    push(0, 0, 1, 16'h0BAD, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    run_table();

    // Stray start pulses mid-load and in the tail, then start+abort together while idle.
    build_load(16'h3C00, 16'h6000, 1'b0, 5);
    push(1, 1, 1, 16'h7777, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    run_table();

    // Asynchronous reset once address 20 has been written, then a clean full load.
    build_partial(16'h4400, 16'h7000, 21);
    run_table();
    @(negedge clk);
    bus.cfg_vld  = 1'b1;
    bus.cfg_data = 16'h7015;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    bus.cfg_vld = 1'b0;
    rst_n       = 1'b1;
    m_scale = '0;
    m_addr  = '0;
    m_wdata = '0;
    build_load(16'h3F80, 16'h4000, 1'b0, -1);
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
